dma_controller: RTL and testbench

- Single-channel memory-to-memory DMA engine that drives the secondary (DMA) requester port of the system bus multiplexer.
- It accepts a source address, destination address and byte count, then copies one byte per read/write pair by requesting the bus and waiting for the grant.
- It yields automatically to the core because the multiplexer gives the core priority; the engine only advances on its own grant.
- Completion is reported with a one-cycle pulse; progress is visible through the remaining-count output.

---
 rtl/dma_controller_if.sv | 36 +++
 rtl/dma_controller.sv | 161 ++++++++++++++++
 tb/tb_dma_controller.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_controller_if.sv
// Bus-side port bundle of the DMA engine: the secondary requester port of the
// system bus multiplexer (address, direction, request, grant, data).
interface dma_controller_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
);
  logic [ADDRESS_WIDTH-1:0] DMA_ADDR;
  logic                     DMA_RW;
  logic                     DMA_BR;
  logic                     DMA_BA;
  logic [DATA_WIDTH-1:0]    DMA_DIN;
  logic [DATA_WIDTH-1:0]    DMA_DOUT;
  logic                     DMA_DOE;

  // DMA engine side
  modport master (
    output DMA_ADDR,
    output DMA_RW,
    output DMA_BR,
    output DMA_DOUT,
    output DMA_DOE,
    input  DMA_BA,
    input  DMA_DIN
  );

  // bus multiplexer side
  modport slave (
    input  DMA_ADDR,
    input  DMA_RW,
    input  DMA_BR,
    input  DMA_DOUT,
    input  DMA_DOE,
    output DMA_BA,
    output DMA_DIN
  );
endinterface

// File: rtl/dma_controller.sv
// dma_controller: single-channel memory-to-memory DMA engine. Copies LEN bytes
// from SRC to DST, one granted read plus one granted write per byte, on the
// secondary requester port of the bus multiplexer. The core has priority on the
// multiplexer, so a withheld grant simply stalls the engine.
// Optional feature: define DMA_ABORT_EN to add the ABORT input.
//
// state | meaning
// IDLE  | waiting for START; bus released
// RD    | requesting bus, reading byte at src_q
// WR    | requesting bus, writing captured byte to dst_q
// FIN   | one-cycle DONE pulse, START ignored
module dma_controller #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [ADDRESS_WIDTH-1:0] SRC,
  input  logic [ADDRESS_WIDTH-1:0] DST,
  input  logic [LEN_WIDTH-1:0]     LEN,
`ifdef DMA_ABORT_EN
  input  logic                     ABORT,
`endif
  output logic                     BUSY,
  output logic                     DONE,
  output logic [LEN_WIDTH-1:0]     REMAIN,
  dma_controller_if.master         bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]     LEN_ONE  = LEN_WIDTH'(1);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] src_q;
  logic [ADDRESS_WIDTH-1:0] dst_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [LEN_WIDTH-1:0]     remain_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     br_q;
  logic                     doe_q;
  logic                     rw_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;

  logic                     abort_hit;
  logic [ADDRESS_WIDTH-1:0] src_next;

`ifdef DMA_ABORT_EN
  assign abort_hit = ABORT;
`else
  assign abort_hit = 1'b0;
`endif

  // address increments wrap naturally at the register width
  assign src_next = src_q + ADDR_ONE;

  // Sequencer: state, latched transfer parameters and all registered bus outputs.
  // Every output is a flop so nothing on the bus depends combinationally on DMA_BA.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      br_q     <= 1'b0;
      doe_q    <= 1'b0;
      rw_q     <= 1'b1;
      addr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            src_q    <= SRC;
            dst_q    <= DST;
            remain_q <= LEN;
            addr_q   <= SRC;
            if (LEN != '0) begin
              state  <= S_RD;
              busy_q <= 1'b1;
              br_q   <= 1'b1;
            end else begin
              state  <= S_FIN;
              done_q <= 1'b1;
            end
          end
        end

        S_RD: begin
          if (abort_hit) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            br_q   <= 1'b0;
          end else if (bus.DMA_BA) begin
            data_q <= bus.DMA_DIN;
            state  <= S_WR;
            rw_q   <= 1'b0;
            doe_q  <= 1'b1;
            addr_q <= dst_q;
          end
        end

        S_WR: begin
          // a write granted on the abort edge still completes and is counted
          if (bus.DMA_BA) begin
            src_q    <= src_next;
            dst_q    <= dst_q + ADDR_ONE;
            remain_q <= remain_q - LEN_ONE;
          end
          if (abort_hit || bus.DMA_BA) begin
            rw_q   <= 1'b1;
            doe_q  <= 1'b0;
            addr_q <= bus.DMA_BA ? src_next : src_q;
            if (abort_hit || (remain_q == LEN_ONE)) begin
              busy_q <= 1'b0;
              br_q   <= 1'b0;
              if (abort_hit) begin
                state <= S_IDLE;
              end else begin
                state  <= S_FIN;
                done_q <= 1'b1;
              end
            end else begin
              state <= S_RD;
            end
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign REMAIN       = remain_q;
  assign bus.DMA_ADDR = addr_q;
  assign bus.DMA_RW   = rw_q;
  assign bus.DMA_BR   = br_q;
  assign bus.DMA_DOE  = doe_q;
  assign bus.DMA_DOUT = data_q;

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: transaction-level model (byte counter plus a
// synthetic source memory) compared against the DUT every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_dma_controller;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LW = 16;
`ifdef DMA_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic          CLK   = 1'b0;
  logic          RST   = 1'b1;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic          ba    = 1'b0;
  logic [AW-1:0] SRC   = '0;
  logic [AW-1:0] DST   = '0;
  logic [LW-1:0] LEN   = '0;
  logic          BUSY;
  logic          DONE;
  logic [LW-1:0] REMAIN;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // synthetic source memory contents
  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  dma_controller_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  assign bus.DMA_BA  = ba;
  assign bus.DMA_DIN = mem_fn(bus.DMA_ADDR);

  dma_controller #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .SRC    (SRC),
    .DST    (DST),
    .LEN    (LEN),
`ifdef DMA_ABORT_EN
    .ABORT  (ABORT),
`endif
    .BUSY   (BUSY),
    .DONE   (DONE),
    .REMAIN (REMAIN),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  // transaction model: a transfer is (src, dst, len) and k bytes already copied
  bit          m_active  = 1'b0;
  bit          m_writing = 1'b0;
  bit          m_done    = 1'b0;
  logic [15:0] m_src     = '0;
  logic [15:0] m_dst     = '0;
  int          m_len     = 0;
  int          m_k       = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_active = 0; m_writing = 0; m_done = 0;
      m_src = '0; m_dst = '0; m_len = 0; m_k = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (START) begin
        m_src = SRC; m_dst = DST; m_len = int'(LEN); m_k = 0; m_writing = 0;
        if (LEN == 0) m_done = 1;
        else m_active = 1;
      end
    end else if (ABORT_EN && ABORT) begin
      if (m_writing && ba) m_k++;
      m_active = 0;
      m_writing = 0;
    end else if (ba) begin
      if (m_writing) begin
        m_k++;
        m_writing = 0;
        if (m_k == m_len) begin
          m_active = 0;
          m_done = 1;
        end
      end else begin
        m_writing = 1;
      end
    end
  end

  int          busy_cnt = 0;
  int          done_cnt = 0;
  int          br_cnt   = 0;
  logic [15:0] rd_q[$];
  logic [23:0] wr_q[$];

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("BUSY", BUSY, m_active);
      chk("DONE", DONE, m_done);
      chk("REMAIN", REMAIN, 32'(m_len - m_k));
      chk("DMA_BR", bus.DMA_BR, m_active);
      chk("DMA_RW", bus.DMA_RW, !(m_active && m_writing));
      chk("DMA_DOE", bus.DMA_DOE, m_active && m_writing);
      chk("DMA_ADDR", bus.DMA_ADDR,
          (m_active && m_writing) ? 16'(m_dst + m_k) : 16'(m_src + m_k));
      if (m_active && m_writing)
        chk("DMA_DOUT", bus.DMA_DOUT, mem_fn(16'(m_src + m_k)));
      if (BUSY === 1'b1) busy_cnt++;
      if (DONE === 1'b1) done_cnt++;
      if (bus.DMA_BR === 1'b1) br_cnt++;
      if (bus.DMA_BR === 1'b1 && ba) begin
        if (bus.DMA_RW === 1'b1 && !(ABORT_EN && ABORT)) rd_q.push_back(bus.DMA_ADDR);
        if (bus.DMA_RW === 1'b0) wr_q.push_back({bus.DMA_ADDR, bus.DMA_DOUT});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_stats();
    busy_cnt = 0;
    done_cnt = 0;
    br_cnt = 0;
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic start_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    SRC = s;
    DST = d;
    LEN = n;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk(name, seen, 1);
    tick();
  endtask

  task automatic check_logs(input string name, input logic [15:0] s, input logic [15:0] d, input int n);
    chk({name, "_nrd"}, rd_q.size(), n);
    chk({name, "_nwr"}, wr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rd_q.size()) chk({name, "_rd"}, rd_q[i], 16'(s + i));
      if (i < wr_q.size()) chk({name, "_wr"}, wr_q[i], {16'(d + i), mem_fn(16'(s + i))});
    end
  endtask

  initial begin
    #1 RST = 1'b0;
    #2;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_remain", REMAIN, 0);
    chk("rst_br", bus.DMA_BR, 0);
    chk("rst_doe", bus.DMA_DOE, 0);
    chk("rst_rw", bus.DMA_RW, 1);
    chk("rst_addr", bus.DMA_ADDR, 0);
    chk("rst_dout", bus.DMA_DOUT, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    chk_en = 1'b1;
    tick();

    // basic copy under continuous grant
    clear_stats();
    ba = 1'b1;
    start_xfer(16'h1000, 16'h2000, 16'd3);
    wait_done("t1_done");
    chk("t1_busy_cycles", busy_cnt, 6);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_remain", REMAIN, 0);
    check_logs("t1", 16'h1000, 16'h2000, 3);

    // zero length: DONE only, no bus request
    clear_stats();
    start_xfer(16'h0111, 16'h0222, 16'd0);
    wait_done("t2_done");
    chk("t2_br_cycles", br_cnt, 0);
    chk("t2_busy_cycles", busy_cnt, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // address wrap
    clear_stats();
    start_xfer(16'hFFFF, 16'h7FFF, 16'd2);
    wait_done("t3_done");
    check_logs("t3", 16'hFFFF, 16'h7FFF, 2);
    chk("t3_rd1_wrapped", (rd_q.size() > 1) ? 32'(rd_q[1]) : 32'hDEAD, 32'h0000);

    // grant withheld for 5 cycles in the first write
    clear_stats();
    ba = 1'b1;
    start_xfer(16'h0300, 16'h0400, 16'd3);
    tick();
    ba = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("t4_stall_addr", bus.DMA_ADDR, 16'h0400);
      chk("t4_stall_dout", bus.DMA_DOUT, mem_fn(16'h0300));
      chk("t4_stall_doe", bus.DMA_DOE, 1);
      chk("t4_stall_br", bus.DMA_BR, 1);
      @(posedge CLK);
      #1;
    end
    ba = 1'b1;
    wait_done("t4_done");
    chk("t4_busy_cycles", busy_cnt, 11);
    check_logs("t4", 16'h0300, 16'h0400, 3);

    // asynchronous reset during the second write of a 4-byte copy
    clear_stats();
    start_xfer(16'h0600, 16'h0700, 16'd4);
    tick();
    tick();
    tick();
    chk("t5_in_wr", bus.DMA_DOE, 1);
    #1 RST = 1'b0;
    #1;
    chk("t5_rst_busy", BUSY, 0);
    chk("t5_rst_br", bus.DMA_BR, 0);
    chk("t5_rst_doe", bus.DMA_DOE, 0);
    chk("t5_rst_done", DONE, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    tick();
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_nwr", wr_q.size(), 1);
    clear_stats();
    start_xfer(16'h0800, 16'h0900, 16'd2);
    wait_done("t5b_done");
    check_logs("t5b", 16'h0800, 16'h0900, 2);

`ifdef DMA_ABORT_EN
    // abort during the read of byte 3 of 5
    clear_stats();
    start_xfer(16'h0A00, 16'h0B00, 16'd5);
    tick();
    tick();
    tick();
    tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    @(negedge CLK);
    chk("t6_remain", REMAIN, 3);
    chk("t6_busy", BUSY, 0);
    chk("t6_br", bus.DMA_BR, 0);
    tick();
    tick();
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_nwr", wr_q.size(), 2);
`endif

    // randomized traffic: grant gaps, START while busy, optional aborts
    clear_stats();
    for (int c = 0; c < 3000; c++) begin
      ba    = ($urandom % 4) != 0;
      START = ($urandom % 3) == 0;
      SRC   = (($urandom % 4) == 0) ? 16'(16'hFFFC + ($urandom % 4)) : 16'($urandom);
      DST   = (($urandom % 4) == 0) ? 16'(16'hFFFD + ($urandom % 3)) : 16'($urandom);
      LEN   = 16'($urandom % 6);
      ABORT = ABORT_EN && (($urandom % 20) == 0);
      tick();
    end
    START = 1'b0;
    ABORT = 1'b0;
    ba    = 1'b1;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
